// File: rtl/gate_stats_pkg.sv
// Shared definitions for the reduction-gate statistics window: state encoding
// and the sample consistency rule used by both the design and its benches.
package gate_stats_pkg;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    // Flag combinations a real 4-bit AND/OR/XOR reduction can never produce.
    function automatic logic is_inconsistent(input logic f_and, input logic f_or, input logic f_xor);
        return (f_and & ~f_or) | (f_and & f_xor) | (~f_or & f_xor);
    endfunction

endpackage

// File: rtl/gate_stats_window_counter.sv
// Window-local up-counter with synchronous clear; clear wins over increment.
module win_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q + CW'(1);
        end
    end

endmodule

// File: rtl/gate_stats_window.sv
// Collects AND/OR/XOR reduction flags over WINDOW accepted samples, flags
// inconsistent samples, and hands per-window counts downstream via valid/ready.
module gate_stats_window
    import gate_stats_pkg::*;
#(
    parameter  int WINDOW = 16,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_and,
    input  logic          out_or,
    input  logic          out_xor,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] cnt_and,
    output logic [CW-1:0] cnt_or,
    output logic [CW-1:0] cnt_xor,
    output logic [CW-1:0] cnt_err,
    output logic          err_seen
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] idx;
    logic          accept;
    logic          last_accept;
    logic          handshake;
    logic          bad_sample;
    logic          cnt_clr;
    logic          idx_clr;

    // clear drops any sample presented alongside it, even though in_ready=1.
    assign accept      = (state == ST_ACCUM) & in_valid & ~clear;
    assign last_accept = accept & (idx == LAST_IDX);
    assign handshake   = (state == ST_REPORT) & res_ready;
    assign bad_sample  = is_inconsistent(out_and, out_or, out_xor);
    assign cnt_clr     = clear | handshake;
    assign idx_clr     = clear | last_accept;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (last_accept) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
        if (clear) state_nxt = ST_ACCUM;
    end

    // Sticky across windows; only reset or clear drops it.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            err_seen <= 1'b0;
        end else if (clear) begin
            err_seen <= 1'b0;
        end else if (accept & bad_sample) begin
            err_seen <= 1'b1;
        end
    end

    win_counter #(.CW(CW)) u_cnt_and (
        .clk(clk), .areset_n(areset_n), .clr(cnt_clr), .inc(accept & out_and), .q(cnt_and)
    );

    win_counter #(.CW(CW)) u_cnt_or (
        .clk(clk), .areset_n(areset_n), .clr(cnt_clr), .inc(accept & out_or), .q(cnt_or)
    );

    win_counter #(.CW(CW)) u_cnt_xor (
        .clk(clk), .areset_n(areset_n), .clr(cnt_clr), .inc(accept & out_xor), .q(cnt_xor)
    );

    win_counter #(.CW(CW)) u_cnt_err (
        .clk(clk), .areset_n(areset_n), .clr(cnt_clr), .inc(accept & bad_sample), .q(cnt_err)
    );

    // Index wraps to 0 on the window's final sample, ready for the next window.
    win_counter #(.CW(CW)) u_idx (
        .clk(clk), .areset_n(areset_n), .clr(idx_clr), .inc(accept), .q(idx)
    );

endmodule

// File: tb/tb_gate_stats_window.sv
// Self-checking bench: a WINDOW=16 instance driven against a transaction-level
// scoreboard, plus a WINDOW=4 instance for gapped input timing.
module tb_gate_stats_window;
    import gate_stats_pkg::*;

    typedef struct {
        int a;
        int o;
        int x;
        int e;
    } res_t;

    logic clk = 1'b0;
    logic areset_n = 1'b0;

    // WINDOW = 16 instance
    logic       clear = 1'b0, in_valid = 1'b0, in_ready;
    logic       out_and = 1'b0, out_or = 1'b0, out_xor = 1'b0;
    logic       res_valid, res_ready = 1'b0, err_seen;
    logic [4:0] cnt_and, cnt_or, cnt_xor, cnt_err;

    // WINDOW = 4 instance
    logic       clear_4 = 1'b0, in_valid_4 = 1'b0, in_ready_4;
    logic       out_and_4 = 1'b0, out_or_4 = 1'b0, out_xor_4 = 1'b0;
    logic       res_valid_4, res_ready_4 = 1'b1, err_seen_4;
    logic [2:0] cnt_and_4, cnt_or_4, cnt_xor_4, cnt_err_4;

    int checks = 0;
    int errors = 0;

    res_t sb_q[$];
    res_t exp_r;
    int   m_and, m_or, m_xor, m_err, m_idx;
    logic m_rep;

    always #5 clk = ~clk;

    gate_stats_window #(.WINDOW(16)) dut (
        .clk(clk), .areset_n(areset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
        .res_valid(res_valid), .res_ready(res_ready),
        .cnt_and(cnt_and), .cnt_or(cnt_or), .cnt_xor(cnt_xor), .cnt_err(cnt_err),
        .err_seen(err_seen)
    );

    gate_stats_window #(.WINDOW(4)) dut4 (
        .clk(clk), .areset_n(areset_n), .clear(clear_4),
        .in_valid(in_valid_4), .in_ready(in_ready_4),
        .out_and(out_and_4), .out_or(out_or_4), .out_xor(out_xor_4),
        .res_valid(res_valid_4), .res_ready(res_ready_4),
        .cnt_and(cnt_and_4), .cnt_or(cnt_or_4), .cnt_xor(cnt_xor_4), .cnt_err(cnt_err_4),
        .err_seen(err_seen_4)
    );

    // Flags a correct reduction stage produces for a nibble: {and, or, xor}.
    function automatic logic [2:0] red(input logic [3:0] n);
        return {&n, |n, ^n};
    endfunction

    task automatic model_reset();
        m_and = 0; m_or = 0; m_xor = 0; m_err = 0; m_idx = 0;
        m_rep = 1'b0;
        sb_q.delete();
    endtask

    // One clock of stimulus on the WINDOW=16 instance; model follows the edge.
    task automatic step(input logic v, input logic [2:0] f, input logic rr, input logic clr);
        in_valid = v;
        {out_and, out_or, out_xor} = f;
        res_ready = rr;
        clear = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (!m_rep) begin
            if (v) begin
                m_and += int'(f[2]);
                m_or  += int'(f[1]);
                m_xor += int'(f[0]);
                if (is_inconsistent(f[2], f[1], f[0])) m_err++;
                m_idx++;
                if (m_idx == 16) begin
                    sb_q.push_back('{m_and, m_or, m_xor, m_err});
                    m_idx = 0;
                    m_rep = 1'b1;
                end
            end
        end else if (rr) begin
            m_rep = 1'b0;
            m_and = 0; m_or = 0; m_xor = 0; m_err = 0;
        end
        #1;
        clear = 1'b0;
    endtask

    // Scoreboard: each result handshake pops and compares one expected window.
    always @(negedge clk) begin
        if (areset_n && res_valid && res_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_result: got and=%0d or=%0d xor=%0d err=%0d, required no result",
                         cnt_and, cnt_or, cnt_xor, cnt_err);
            end else begin
                exp_r = sb_q.pop_front();
                if (int'(cnt_and) != exp_r.a || int'(cnt_or) != exp_r.o ||
                    int'(cnt_xor) != exp_r.x || int'(cnt_err) != exp_r.e) begin
                    errors++;
                    $display("FAIL sb_result: got and=%0d or=%0d xor=%0d err=%0d, required and=%0d or=%0d xor=%0d err=%0d",
                             cnt_and, cnt_or, cnt_xor, cnt_err, exp_r.a, exp_r.o, exp_r.x, exp_r.e);
                end
            end
        end
    end

    task automatic test_reset();
        model_reset();
        #3;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
        checks++; if (cnt_and !== 5'd0 || cnt_or !== 5'd0 || cnt_xor !== 5'd0 || cnt_err !== 5'd0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d/%0d/%0d required 0/0/0/0", cnt_and, cnt_or, cnt_xor, cnt_err); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset_err_seen: got %b required 0", err_seen); end
        @(posedge clk); #1;
        areset_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_nibble_sweep();
        for (int n = 0; n < 16; n++) step(1'b1, red(4'(n)), 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL sweep_report_flags: got valid=%b ready=%b required 1/0", res_valid, in_ready); end
        checks++; if (cnt_and !== 5'd1 || cnt_or !== 5'd15 || cnt_xor !== 5'd8 || cnt_err !== 5'd0 || err_seen !== 1'b0) begin
            errors++; $display("FAIL sweep_counts: got %0d/%0d/%0d/%0d seen=%b required 1/15/8/0 seen=0",
                               cnt_and, cnt_or, cnt_xor, cnt_err, err_seen); end
        step(1'b0, 3'b000, 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || cnt_or !== 5'd0) begin
            errors++; $display("FAIL sweep_after_handshake: got valid=%b ready=%b or=%0d required 0/1/0",
                               res_valid, in_ready, cnt_or); end
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 16; n++) step(1'b1, red(4'(n)), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (in_ready !== 1'b0 || res_valid !== 1'b1 ||
                          cnt_and !== 5'd1 || cnt_or !== 5'd15 || cnt_xor !== 5'd8) begin
                errors++; $display("FAIL bp_hold_cycle%0d: got ready=%b valid=%b cnt=%0d/%0d/%0d required 0/1 1/15/8",
                                   k, in_ready, res_valid, cnt_and, cnt_or, cnt_xor); end
            if (k < 4) step(1'b1, red(4'h1), 1'b0, 1'b0);
        end
        // Sample held on in_valid during the handshake must not be taken.
        step(1'b1, red(4'h1), 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || cnt_and !== 5'd0 || cnt_or !== 5'd0) begin
            errors++; $display("FAIL bp_after_handshake: got valid=%b ready=%b and=%0d or=%0d required 0/1/0/0",
                               res_valid, in_ready, cnt_and, cnt_or); end
    endtask

    task automatic test_error_inject();
        for (int i = 0; i < 16; i++) step(1'b1, (i == 3) ? 3'b100 : red(4'hF), 1'b1, 1'b0);
        checks++; if (cnt_and !== 5'd16 || cnt_or !== 5'd15 || cnt_xor !== 5'd0 || cnt_err !== 5'd1 || err_seen !== 1'b1) begin
            errors++; $display("FAIL err_counts: got %0d/%0d/%0d/%0d seen=%b required 16/15/0/1 seen=1",
                               cnt_and, cnt_or, cnt_xor, cnt_err, err_seen); end
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, red(4'hF), 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b1 || cnt_err !== 5'd0 || err_seen !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got valid=%b err=%0d seen=%b required 1/0/1", res_valid, cnt_err, err_seen); end
        step(1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) step(1'b1, red(4'hF), 1'b1, 1'b0);
        checks++; if (cnt_and !== 5'd7) begin errors++; $display("FAIL clear_pre_count: got %0d required 7", cnt_and); end
        step(1'b1, red(4'hF), 1'b1, 1'b1);
        checks++; if (cnt_and !== 5'd0 || err_seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_effect: got and=%0d seen=%b ready=%b required 0/0/1", cnt_and, err_seen, in_ready); end
        for (int i = 0; i < 16; i++) step(1'b1, red(4'h1), 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b1 || cnt_and !== 5'd0 || cnt_or !== 5'd16 || cnt_xor !== 5'd16 || cnt_err !== 5'd0) begin
            errors++; $display("FAIL clear_next_window: got valid=%b %0d/%0d/%0d/%0d required 1 0/16/16/0",
                               res_valid, cnt_and, cnt_or, cnt_xor, cnt_err); end
        step(1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) step(1'b1, (i == 2) ? 3'b001 : red(4'hF), 1'b1, 1'b0);
        checks++; if (cnt_and !== 5'd8 || err_seen !== 1'b1) begin
            errors++; $display("FAIL arst_pre_window: got and=%0d seen=%b required 8/1", cnt_and, err_seen); end
        #2 areset_n = 1'b0;
        #1;
        checks++; if (cnt_and !== 5'd0 || cnt_err !== 5'd0 || err_seen !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL arst_mid_window: got and=%0d err=%0d seen=%b valid=%b required 0/0/0/0",
                               cnt_and, cnt_err, err_seen, res_valid); end
        model_reset();
        areset_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, red(4'hF), 1'b0, 1'b0);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_report: got %b required 1", res_valid); end
        #2 areset_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || cnt_and !== 5'd0 || cnt_or !== 5'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_mid_report: got valid=%b and=%0d or=%0d ready=%b required 0/0/0/1",
                               res_valid, cnt_and, cnt_or, in_ready); end
        model_reset();
        areset_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, red(4'h3), 1'b1, 1'b0);
        checks++; if (res_valid !== 1'b1 || cnt_and !== 5'd0 || cnt_or !== 5'd16 || cnt_xor !== 5'd0) begin
            errors++; $display("FAIL arst_next_window: got valid=%b %0d/%0d/%0d required 1 0/16/0",
                               res_valid, cnt_and, cnt_or, cnt_xor); end
        step(1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_gapped_window4();
        logic [3:0] nibs [4];
        nibs = '{4'h3, 4'h7, 4'h8, 4'h0};
        for (int i = 0; i < 4; i++) begin
            in_valid_4 = 1'b1;
            {out_and_4, out_or_4, out_xor_4} = red(nibs[i]);
            @(posedge clk); #1;
            in_valid_4 = 1'b0;
            if (i < 3) begin
                checks++; if (res_valid_4 !== 1'b0) begin
                    errors++; $display("FAIL gap_early_valid%0d: got %b required 0", i, res_valid_4); end
                repeat (2) @(posedge clk);
                #1;
            end
        end
        checks++; if (res_valid_4 !== 1'b1 || cnt_and_4 !== 3'd0 || cnt_or_4 !== 3'd3 ||
                      cnt_xor_4 !== 3'd2 || cnt_err_4 !== 3'd0) begin
            errors++; $display("FAIL gap_report: got valid=%b %0d/%0d/%0d/%0d required 1 0/3/2/0",
                               res_valid_4, cnt_and_4, cnt_or_4, cnt_xor_4, cnt_err_4); end
        @(posedge clk); #1;
        checks++; if (res_valid_4 !== 1'b0 || cnt_or_4 !== 3'd0 || in_ready_4 !== 1'b1) begin
            errors++; $display("FAIL gap_after_handshake: got valid=%b or=%0d ready=%b required 0/0/1",
                               res_valid_4, cnt_or_4, in_ready_4); end
    endtask

    initial begin
        test_reset();
        test_nibble_sweep();
        test_backpressure();
        test_error_inject();
        test_clear();
        test_async_reset();
        test_gapped_window4();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending results required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
